wildcard_match_sequencer: RTL and testbench
===========================================

// Module: wildcard_match_sequencer
// PURPOSE
//  Time-shares one wildcard-equality comparator (==? / !=? semantics) across a table of
//  NUM_ENTRIES programmable pattern/mask entries. Accepts one data word per request and
//  scans the entries one per cycle, lowest index first. Returns the first matching index,
//  or a miss. Sits between a packet/field classifier front-end and downstream steering logic.
// PARAMETERS
//  DATA_W       8   width of request data and pattern entries
//  NUM_ENTRIES  4   number of pattern entries (>=2)
//  IDX_W        $clog2(NUM_ENTRIES)  entry index width (derived, localparam)
//  CNT_W        16  width of saturating hit counter
// PORTS
//  i_clk          in   1          clock, all state on rising edge
//  i_rst_n        in   1          asynchronous active-low reset
//  i_cfg_we       in   1          config write strobe
//  i_cfg_idx      in   IDX_W      entry to write
//  i_cfg_value    in   DATA_W     pattern value
//  i_cfg_mask     in   DATA_W     1 = wildcard bit (pattern X/Z), 0 = must equal
//  i_cfg_en       in   1          entry enable written with the entry
//  o_cfg_err      out  1          1-cycle pulse: write dropped (busy or idx out of range)
//  i_req_valid    in   1          request valid
//  o_req_ready    out  1          high only in IDLE
//  i_req_data     in   DATA_W     word to classify (2-state)
//  o_rsp_valid    out  1          response valid
//  i_rsp_ready    in   1          response accept
//  o_rsp_hit      out  1          1 = some enabled entry matched (==? true)
//  o_rsp_idx      out  IDX_W      first matching index; 0 on miss
//  o_hit_count    out  CNT_W      saturating count of hit responses accepted
// BEHAVIOUR
//  - Match(e) = en[e] & (((data ^ value[e]) & ~mask[e]) == 0). Disabled entry never matches.
//  - Reset: all entries value=0, mask=0, en=0; state IDLE; o_rsp_valid=0, o_rsp_hit=0,
//    o_rsp_idx=0, o_hit_count=0, o_cfg_err=0, o_req_ready=1. Reset mid-scan aborts with no response.
//  - FSM IDLE -> SCAN on i_req_valid & o_req_ready: data latched, scan ptr=0.
//  - SCAN: one entry evaluated per cycle at ptr. Hit -> RESP (hit=1, idx=ptr). No hit and
//    ptr==NUM_ENTRIES-1 -> RESP (hit=0, idx=0). Else ptr+1. No wrap past last entry.
//  - Latency: accept at edge T; hit on entry k gives o_rsp_valid=1 after edge T+1+k;
//    miss gives o_rsp_valid=1 after edge T+NUM_ENTRIES.
//  - RESP: o_rsp_valid held with stable hit/idx until i_rsp_ready; on accept -> IDLE,
//    o_req_ready=1 the following cycle (one request in flight; no back-to-back overlap).
//  - o_hit_count increments on accepted hit responses, saturates at all-ones, never wraps.
//  - Config writes take effect next edge, only in IDLE and only for idx < NUM_ENTRIES;
//    otherwise dropped and o_cfg_err pulses one cycle. Write in the same cycle as a request
//    accept: write is applied and the scan sees the new entry.
//  - Multiple matching entries: lowest index wins (earliest scanned).
// TESTING
//  - Reset, all entries disabled, req 8'h5A -> miss after NUM_ENTRIES cycles, hit=0, idx=0.
//  - Entry2 = value 8'b0101_0100 mask 8'b0000_1001 en=1; req 8'h5D -> hit, idx=2,
//    rsp_valid 3 cycles after accept; req 8'h5E -> miss.
//  - Entry0 mask 8'hFF (all-wildcard) en=1, entry1 exact 8'h33 -> req 8'h33 hits idx 0.
//  - Hold i_rsp_ready=0 for 5 cycles -> rsp fields stable, o_req_ready=0, count unchanged until accept.
//  - Config write during SCAN and write with idx>=NUM_ENTRIES -> o_cfg_err pulse, table unchanged.
//  - Assert i_rst_n low mid-SCAN -> no response, table cleared; preload counter near max -> saturates.

Source files
------------

// File: rtl/wildcard_match_sequencer.sv
// Scans a table of value/mask/enable entries one per cycle against a latched request word
// and returns the first (lowest-index) wildcard match, or a miss; one request in flight.
module wildcard_match_sequencer #(
  parameter int DATA_W      = 8,
  parameter int NUM_ENTRIES = 4,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_we,
  input  logic [IDX_W-1:0]  i_cfg_idx,
  input  logic [DATA_W-1:0] i_cfg_value,
  input  logic [DATA_W-1:0] i_cfg_mask,
  input  logic              i_cfg_en,
  output logic              o_cfg_err,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_hit,
  output logic [IDX_W-1:0]  o_rsp_idx,
  output logic [CNT_W-1:0]  o_hit_count
);

  // Table is padded to a power of two so the scan pointer can index it directly;
  // padding entries can never be written and so stay disabled.
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] value [DEPTH];
  logic [DATA_W-1:0] mask  [DEPTH];
  logic [DEPTH-1:0]  en;

  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0]  ptr;
  logic              hit;
  logic              last;
  logic              cfg_ok;
  logic              rsp_hit_q;
  logic [IDX_W-1:0]  rsp_idx_q;
  logic [CNT_W-1:0]  hit_count_q;
  logic              cfg_err_q;

  assign hit    = en[ptr] & (((data ^ value[ptr]) & ~mask[ptr]) == '0);
  assign last   = (ptr == IDX_W'(NUM_ENTRIES - 1));
  assign cfg_ok = (state == IDLE) && (int'(i_cfg_idx) < NUM_ENTRIES);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nxt = SCAN;
      end
      SCAN: begin
        if (hit || last) state_nxt = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        value[e] <= '0;
        mask[e]  <= '0;
      end
      en          <= '0;
      data        <= '0;
      ptr         <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      hit_count_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      // A write in the accept cycle lands before the first compare, so the scan sees it.
      if (i_cfg_we && cfg_ok) begin
        value[i_cfg_idx] <= i_cfg_value;
        mask[i_cfg_idx]  <= i_cfg_mask;
        en[i_cfg_idx]    <= i_cfg_en;
      end
      cfg_err_q <= i_cfg_we & ~cfg_ok;

      if (state == IDLE && i_req_valid) begin
        data <= i_req_data;
        ptr  <= '0;
      end else if (state == SCAN) begin
        if (hit) begin
          rsp_hit_q <= 1'b1;
          rsp_idx_q <= ptr;
        end else if (last) begin
          rsp_hit_q <= 1'b0;
          rsp_idx_q <= '0;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end

      if (state == RESP && i_rsp_ready && rsp_hit_q && (hit_count_q != '1)) begin
        hit_count_q <= hit_count_q + 1'b1;
      end
    end
  end

  assign o_rsp_hit   = rsp_hit_q;
  assign o_rsp_idx   = rsp_idx_q;
  assign o_hit_count = hit_count_q;
  assign o_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_wildcard_match_sequencer.sv
// Directed + random bench for wildcard_match_sequencer against a bit-level first-match model.
module tb_wildcard_match_sequencer;
  localparam int DW  = 8;
  localparam int NE  = 4;
  localparam int CW  = 3;
  localparam int IW  = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [DW-1:0] cfg_value, cfg_mask;
  logic          cfg_en, cfg_err;
  logic          req_valid, req_ready;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready, rsp_hit;
  logic [IW-1:0] rsp_idx;
  logic [CW-1:0] hit_count;

  wildcard_match_sequencer #(.DATA_W(DW), .NUM_ENTRIES(NE), .CNT_W(CW)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_value(cfg_value), .i_cfg_mask(cfg_mask),
    .i_cfg_en(cfg_en), .o_cfg_err(cfg_err),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_data(req_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_hit(rsp_hit),
    .o_rsp_idx(rsp_idx), .o_hit_count(hit_count)
  );

  // Three-entry instance: the only way to present an index beyond the table.
  logic          c3_we, c3_en, c3_err, q3_valid, q3_ready, s3_valid, s3_ready, s3_hit;
  logic [1:0]    c3_idx, s3_idx;
  logic [DW-1:0] c3_value, c3_mask, q3_data;
  logic [15:0]   s3_cnt;

  wildcard_match_sequencer #(.DATA_W(DW), .NUM_ENTRIES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_we(c3_we), .i_cfg_idx(c3_idx), .i_cfg_value(c3_value), .i_cfg_mask(c3_mask),
    .i_cfg_en(c3_en), .o_cfg_err(c3_err),
    .i_req_valid(q3_valid), .o_req_ready(q3_ready), .i_req_data(q3_data),
    .o_rsp_valid(s3_valid), .i_rsp_ready(s3_ready), .o_rsp_hit(s3_hit),
    .o_rsp_idx(s3_idx), .o_hit_count(s3_cnt)
  );

  logic [DW-1:0] m_val  [NE];
  logic [DW-1:0] m_mask [NE];
  bit            m_en   [NE];
  int            m_cnt;
  int            n_assert = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < NE; e++) begin
      m_val[e] = '0; m_mask[e] = '0; m_en[e] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // First enabled entry whose non-wildcard bits all equal the data bits.
  task automatic model_lookup(input logic [DW-1:0] d, output bit hit, output int idx);
    hit = 1'b0; idx = 0;
    for (int e = 0; e < NE; e++) begin
      bit ok = m_en[e];
      for (int b = 0; b < DW; b++)
        if (!m_mask[e][b] && (d[b] != m_val[e][b])) ok = 1'b0;
      if (ok && !hit) begin hit = 1'b1; idx = e; end
    end
  endtask

  task automatic cfg_write(input int idx, input logic [DW-1:0] v, input logic [DW-1:0] m, input bit e);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_value = v; cfg_mask = m; cfg_en = e;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_val[idx] = v; m_mask[idx] = m; m_en[idx] = e;
    check("cfg_err_idle_write", cfg_err, 0);
  endtask

  // mode 0: plain; 1: cfg write in the accept cycle (applied); 2: cfg write in first scan cycle (dropped)
  task automatic do_req(input logic [DW-1:0] d, input int hold, input int mode,
                        input int widx, input logic [DW-1:0] wv, input logic [DW-1:0] wm);
    bit eh; int ei; int exp_lat; int cyc;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_data = d;
    if (mode == 1) begin
      cfg_we = 1'b1; cfg_idx = IW'(widx); cfg_value = wv; cfg_mask = wm; cfg_en = 1'b1;
      m_val[widx] = wv; m_mask[widx] = wm; m_en[widx] = 1'b1;
    end
    model_lookup(d, eh, ei);
    exp_lat = eh ? ei + 1 : NE;
    @(posedge clk); #1;
    req_valid = 1'b0; cfg_we = 1'b0;
    check("scan_no_rsp_yet", rsp_valid, 0);
    check("req_ready_busy", req_ready, 0);
    if (mode == 2) begin
      cfg_we = 1'b1; cfg_idx = IW'(widx); cfg_value = wv; cfg_mask = wm; cfg_en = 1'b1;
    end
    cyc = 0;
    while (!rsp_valid && cyc < 3 * NE) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 2 && cyc == 1) begin
        check("cfg_err_busy", cfg_err, 1);
        cfg_we = 1'b0;
      end
      if (mode == 2 && cyc == 2) check("cfg_err_one_cycle", cfg_err, 0);
    end
    cfg_we = 1'b0;
    check("rsp_latency", cyc, exp_lat);
    if (!rsp_valid) return;
    check("rsp_hit", rsp_hit, eh);
    check("rsp_idx", rsp_idx, eh ? ei : 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_hit", rsp_hit, eh);
      check("hold_idx", rsp_idx, eh ? ei : 0);
      check("hold_req_ready", req_ready, 0);
      check("hold_count", hit_count, m_cnt);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (eh && m_cnt < MAXC) m_cnt++;
    check("post_accept_valid", rsp_valid, 0);
    check("post_accept_ready", req_ready, 1);
    check("hit_count", hit_count, m_cnt);
  endtask

  initial begin
    int cyc;
    logic [DW-1:0] d;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_value = '0; cfg_mask = '0; cfg_en = 1'b0;
    req_valid = 1'b0; req_data = '0; rsp_ready = 1'b0;
    c3_we = 1'b0; c3_idx = '0; c3_value = '0; c3_mask = '0; c3_en = 1'b0;
    q3_valid = 1'b0; q3_data = '0; s3_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_hit", rsp_hit, 0);
    check("rst_rsp_idx", rsp_idx, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Out-of-range index on the three-entry table: dropped, error pulse, later miss.
    c3_we = 1'b1; c3_idx = 2'd3; c3_value = 8'hC3; c3_mask = 8'h00; c3_en = 1'b1;
    @(posedge clk); #1;
    c3_we = 1'b0;
    check("oor_cfg_err", c3_err, 1);
    @(posedge clk); #1;
    check("oor_cfg_err_clear", c3_err, 0);
    q3_valid = 1'b1; q3_data = 8'hC3;
    @(posedge clk); #1;
    q3_valid = 1'b0;
    cyc = 0;
    while (!s3_valid && cyc < 12) begin @(posedge clk); #1; cyc++; end
    check("oor_miss_latency", cyc, 3);
    check("oor_miss_hit", s3_hit, 0);
    s3_ready = 1'b1;

    // All entries disabled: miss.
    do_req(8'h5A, 0, 0, 0, 0, 0);
    cfg_write(2, 8'b0101_0100, 8'b0000_1001, 1'b1);
    do_req(8'h5D, 0, 0, 0, 0, 0);
    do_req(8'h5E, 0, 0, 0, 0, 0);
    cfg_write(0, 8'h00, 8'hFF, 1'b1);
    cfg_write(1, 8'h33, 8'h00, 1'b1);
    do_req(8'h33, 5, 0, 0, 0, 0);

    // Write during scan is dropped; a second request confirms the table kept its old entry.
    cfg_write(0, 8'h00, 8'hFF, 1'b0);
    do_req(8'hA7, 0, 2, 3, 8'hA7, 8'h00);
    do_req(8'hA7, 1, 0, 0, 0, 0);
    // Write landing in the accept cycle is seen by that scan.
    do_req(8'hA7, 0, 1, 3, 8'hA7, 8'h00);

    // Reset while scanning toward entry 1: no response, table cleared.
    req_valid = 1'b1; req_data = 8'h33;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("midscan_rst_valid", rsp_valid, 0);
    check("midscan_rst_ready", req_ready, 1);
    check("midscan_rst_count", hit_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    do_req(8'h33, 0, 0, 0, 0, 0);

    // Saturation of the hit counter.
    cfg_write(0, 8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < MAXC + 3; i++) do_req(DW'($urandom), 0, 0, 0, 0, 0);

    // Random table contents and requests, biased toward near-matches.
    for (int i = 0; i < 30; i++) begin
      int e;
      if ($urandom_range(0, 2) == 0)
        cfg_write($urandom_range(0, NE - 1), DW'($urandom), DW'($urandom) & DW'($urandom),
                  1'($urandom_range(0, 3) != 0));
      e = $urandom_range(0, NE - 1);
      d = ($urandom_range(0, 1) == 0) ? DW'($urandom) : (m_val[e] ^ (DW'($urandom) & m_mask[e]));
      if ($urandom_range(0, 4) == 0)
        do_req(d, $urandom_range(0, 2), 1, $urandom_range(0, NE - 1), DW'($urandom), DW'($urandom) & DW'($urandom));
      else
        do_req(d, $urandom_range(0, 2), 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
